// File: rtl/stm_capture.sv
// Ping-pong frame capture for transducer intensity/phase samples.
// One bank fills while the other is published to the reader; banks swap on UPDATE.
module stm_capture #(
    parameter int unsigned DEPTH = 249
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       DIN_VALID,
    input  logic [7:0] INTENSITY_IN,
    input  logic [7:0] PHASE_IN,
    input  logic       UPDATE,
    input  logic [7:0] READ_IDX,
    output logic [7:0] INTENSITY_OUT,
    output logic [7:0] PHASE_OUT,
    output logic       READ_VALID,
    output logic       FRAME_DONE,
    output logic       OVERFLOW
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    typedef enum logic {CAPTURE, FULL} state_t;

    state_t        state, state_n;
    logic [AW-1:0] wr_cnt, wr_cnt_n;
    logic          bank, bank_n;
    logic          pending, pending_n;
    logic          read_valid_n, overflow_n, frame_done_n;
    logic          we;
    logic          rd_hit;

    logic [15:0] mem [0:1][0:DEPTH-1];

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= CAPTURE;
            wr_cnt     <= '0;
            bank       <= 1'b0;
            pending    <= 1'b0;
            READ_VALID <= 1'b0;
            FRAME_DONE <= 1'b0;
            OVERFLOW   <= 1'b0;
        end else begin
            state      <= state_n;
            wr_cnt     <= wr_cnt_n;
            bank       <= bank_n;
            pending    <= pending_n;
            READ_VALID <= read_valid_n;
            FRAME_DONE <= frame_done_n;
            OVERFLOW   <= overflow_n;
        end
    end

    always_comb begin
        state_n      = state;
        wr_cnt_n     = wr_cnt;
        bank_n       = bank;
        pending_n    = pending;
        read_valid_n = READ_VALID;
        overflow_n   = OVERFLOW;
        frame_done_n = 1'b0;
        we           = 1'b0;
        case (state)
            CAPTURE: begin
                // An early UPDATE is only remembered; the swap waits for the frame to fill.
                if (UPDATE) pending_n = 1'b1;
                if (DIN_VALID) begin
                    we = ~RST;
                    if (wr_cnt == LAST) begin
                        state_n      = FULL;
                        frame_done_n = 1'b1;
                    end else begin
                        wr_cnt_n = wr_cnt + AW'(1);
                    end
                end
            end
            FULL: begin
                if (DIN_VALID) overflow_n = 1'b1;
                if (UPDATE || pending) begin
                    state_n      = CAPTURE;
                    bank_n       = ~bank;
                    wr_cnt_n     = '0;
                    pending_n    = 1'b0;
                    read_valid_n = 1'b1;
                end
            end
            default: state_n = CAPTURE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (we) mem[bank][wr_cnt] <= {INTENSITY_IN, PHASE_IN};
    end

    assign rd_hit = READ_VALID && (32'(READ_IDX) < DEPTH);

    always_ff @(posedge CLK) begin
        if (RST || !rd_hit) begin
            INTENSITY_OUT <= '0;
            PHASE_OUT     <= '0;
        end else begin
            {INTENSITY_OUT, PHASE_OUT} <= mem[~bank][READ_IDX[AW-1:0]];
        end
    end

endmodule

// File: tb/tb_stm_capture.sv
// Directed bench for stm_capture: read results are queued when a read is
// issued and compared when the registered output appears one cycle later.
module tb_stm_capture;

    localparam int unsigned DEPTH = 249;

    logic       CLK = 1'b0;
    logic       RST;
    logic       DIN_VALID;
    logic [7:0] INTENSITY_IN;
    logic [7:0] PHASE_IN;
    logic       UPDATE;
    logic [7:0] READ_IDX;
    logic [7:0] INTENSITY_OUT;
    logic [7:0] PHASE_OUT;
    logic       READ_VALID;
    logic       FRAME_DONE;
    logic       OVERFLOW;

    int tests = 0;
    int fails = 0;
    int fd_pulses = 0;
    int fd0;
    logic [15:0] exp_q[$];

    stm_capture #(.DEPTH(DEPTH)) dut (
        .CLK(CLK),
        .RST(RST),
        .DIN_VALID(DIN_VALID),
        .INTENSITY_IN(INTENSITY_IN),
        .PHASE_IN(PHASE_IN),
        .UPDATE(UPDATE),
        .READ_IDX(READ_IDX),
        .INTENSITY_OUT(INTENSITY_OUT),
        .PHASE_OUT(PHASE_OUT),
        .READ_VALID(READ_VALID),
        .FRAME_DONE(FRAME_DONE),
        .OVERFLOW(OVERFLOW)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
        if (FRAME_DONE === 1'b1) fd_pulses++;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] pat_val(input int pat, input int i);
        case (pat)
            1:       return {8'(i), 8'(255 - i)};
            2:       return {8'(i * 3), 8'(i + 7)};
            3:       return {8'(i), 8'h33};
            4:       return 16'h1111;
            5:       return 16'h2222;
            6:       return {8'(i) ^ 8'hA5, 8'(i)};
            7:       return {8'h77, 8'(i)};
            default: return 16'hEEEE;
        endcase
    endfunction

    task automatic send_range(input int pat, input int first, input int last,
                              input int upd_a, input int upd_b);
        logic [15:0] v;
        for (int i = first; i <= last; i++) begin
            v            = pat_val(pat, i);
            DIN_VALID    = 1'b1;
            INTENSITY_IN = v[15:8];
            PHASE_IN     = v[7:0];
            UPDATE       = (i == upd_a) || (i == upd_b);
            tick();
        end
        DIN_VALID = 1'b0;
        UPDATE    = 1'b0;
    endtask

    task automatic read_check(input string tag, input logic [7:0] idx, input logic [15:0] exp);
        logic [15:0] e;
        exp_q.push_back(exp);
        READ_IDX = idx;
        tick();
        e = exp_q.pop_front();
        check(tag, {16'h0, INTENSITY_OUT, PHASE_OUT}, {16'h0, e});
    endtask

    task automatic pulse_update();
        UPDATE = 1'b1;
        tick();
        UPDATE = 1'b0;
    endtask

    initial begin
        RST = 1'b1; DIN_VALID = 1'b0; INTENSITY_IN = '0; PHASE_IN = '0;
        UPDATE = 1'b0; READ_IDX = '0;
        tick();
        tick();
        check("rst_rv", READ_VALID, 0);
        check("rst_fd", FRAME_DONE, 0);
        check("rst_ovf", OVERFLOW, 0);
        check("rst_out", {INTENSITY_OUT, PHASE_OUT}, 0);
        RST = 1'b0;
        read_check("notready_rd0", 8'd0, 16'h0000);

        // Basic frame
        fd0 = fd_pulses;
        send_range(1, 0, 247, -1, -1);
        check("basic_fd_early", 32'(fd_pulses - fd0), 0);
        send_range(1, 248, 248, -1, -1);
        check("basic_fd_pulse", FRAME_DONE, 1);
        check("basic_fd_once", 32'(fd_pulses - fd0), 1);
        tick();
        check("basic_fd_width", FRAME_DONE, 0);
        check("basic_rv_prepub", READ_VALID, 0);
        check("basic_ovf", OVERFLOW, 0);
        pulse_update();
        check("basic_rv_pub", READ_VALID, 1);
        read_check("basic_rd10", 8'd10, 16'h0AF5);
        read_check("basic_rd248", 8'd248, 16'hF807);
        read_check("oor_rd249", 8'd249, 16'h0000);
        read_check("oor_rd255", 8'd255, 16'h0000);

        // Early UPDATE at 100 and a merged second one at 150
        send_range(2, 0, 247, 100, 150);
        read_check("early_old", 8'd10, 16'h0AF5);
        send_range(2, 248, 248, -1, -1);
        read_check("early_swapedge_old", 8'd10, 16'h0AF5);
        read_check("early_new10", 8'd10, 16'h1E11);
        read_check("early_new200", 8'd200, 16'h58CF);

        // No leftover pending swap; then overflow
        send_range(3, 0, 248, -1, -1);
        tick();
        tick();
        read_check("merge_nopend", 8'd10, 16'h1E11);
        check("ovf_pre", OVERFLOW, 0);
        send_range(8, 0, 2, -1, -1);
        check("ovf_set", OVERFLOW, 1);
        tick(); tick(); tick();
        check("ovf_sticky", OVERFLOW, 1);
        read_check("ovf_rd_old", 8'd10, 16'h1E11);
        pulse_update();
        read_check("ovf_keep0", 8'd0, 16'h0033);
        read_check("ovf_keep1", 8'd1, 16'h0133);
        read_check("ovf_keep248", 8'd248, 16'hF833);
        check("ovf_sticky2", OVERFLOW, 1);

        // UPDATE coincident with final write, then ping-pong isolation
        send_range(4, 0, 248, 248, -1);
        check("coinc_fd", FRAME_DONE, 1);
        read_check("coinc_swapedge_old", 8'd5, 16'h0533);
        read_check("coinc_pubA", 8'd5, 16'h1111);
        send_range(5, 0, 248, -1, -1);
        tick();
        read_check("iso_A0", 8'd0, 16'h1111);
        read_check("iso_A248", 8'd248, 16'h1111);
        pulse_update();
        read_check("iso_B0", 8'd0, 16'h2222);
        read_check("iso_B100", 8'd100, 16'h2222);

        // Reset mid-frame, with DIN_VALID and UPDATE in the reset cycle
        send_range(6, 0, 49, -1, -1);
        RST = 1'b1; DIN_VALID = 1'b1; UPDATE = 1'b1;
        tick();
        RST = 1'b0; DIN_VALID = 1'b0; UPDATE = 1'b0;
        check("midrst_rv", READ_VALID, 0);
        check("midrst_ovf", OVERFLOW, 0);
        check("midrst_out", {INTENSITY_OUT, PHASE_OUT}, 0);
        read_check("midrst_rd0", 8'd0, 16'h0000);
        fd0 = fd_pulses;
        send_range(6, 0, 247, -1, -1);
        check("midrst_fd_early", 32'(fd_pulses - fd0), 0);
        check("midrst_rv_cap", READ_VALID, 0);
        send_range(6, 248, 248, -1, -1);
        check("midrst_fd_pulse", FRAME_DONE, 1);
        tick();
        check("midrst_fd_once", 32'(fd_pulses - fd0), 1);
        pulse_update();
        read_check("midrst_rd0_new", 8'd0, 16'hA500);
        read_check("midrst_rd248", 8'd248, 16'h5DF8);
        check("midrst_ovf_end", OVERFLOW, 0);

        // Sample on the swap edge is dropped and flags overflow
        send_range(7, 0, 248, -1, -1);
        check("drop_ovf_pre", OVERFLOW, 0);
        DIN_VALID = 1'b1; INTENSITY_IN = 8'hEE; PHASE_IN = 8'hEE; UPDATE = 1'b1;
        tick();
        DIN_VALID = 1'b0; UPDATE = 1'b0;
        check("drop_ovf", OVERFLOW, 1);
        read_check("drop_pub3", 8'd3, 16'h7703);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
